// File: rtl/ahbl_master_arbiter_if.sv
// AHB-Lite address/data bundle shared by the masters and the arbitrated bus.
// The master modport issues transfers; the slave modport answers them.
interface ahbl_master_arbiter_if;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;

    modport master (
        output HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        input  HREADY, HRDATA
    );

    modport slave (
        input  HADDR, HTRANS, HSIZE, HWRITE, HWDATA,
        output HREADY, HRDATA
    );
endinterface

// File: rtl/ahbl_master_arbiter.sv
// Two-master AHB-Lite arbiter: one master owns each address phase, the loser
// is buffered and stalled through its own HREADY until the bus takes it.
module ahbl_master_arbiter #(
    parameter bit ROUND_ROBIN = 1'b1
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahbl_master_arbiter_if.slave  m0,
    ahbl_master_arbiter_if.slave  m1,
    ahbl_master_arbiter_if.master bus
);

    localparam logic [1:0] OWN_NONE    = 2'd0;
    localparam logic [1:0] OWN_M0      = 2'd1;
    localparam logic [1:0] OWN_M1      = 2'd2;
    localparam logic [1:0] HTRANS_IDLE = 2'b00;
    localparam logic [1:0] HTRANS_NSEQ = 2'b10;

    logic [1:0]  pend_v;
    logic [31:0] pend_addr [2];
    logic [2:0]  pend_size [2];
    logic [1:0]  pend_write;
    logic [1:0]  data_own;
    logic        lock_v;
    logic        lock_id;
    logic        last_win;

    logic [31:0] in_addr [2];
    logic [2:0]  in_size [2];
    logic [1:0]  in_write;
    logic [1:0]  in_act;
    logic [1:0]  rdy;
    logic [1:0]  live;
    logic [1:0]  req;
    logic        grant;
    logic        any_req;
    logic        done;
    logic [31:0] src_addr;
    logic [2:0]  src_size;
    logic        src_write;

    always_comb begin
        in_addr[0] = m0.HADDR;
        in_addr[1] = m1.HADDR;
        in_size[0] = m0.HSIZE;
        in_size[1] = m1.HSIZE;
        in_write   = {m1.HWRITE, m0.HWRITE};
        in_act     = {m1.HTRANS[1], m0.HTRANS[1]};
    end

    // A master is held off only while its own captured transfer is queued,
    // except during its own data phase where the slave's HREADY passes through.
    always_comb begin
        rdy[0] = !pend_v[0];
        rdy[1] = !pend_v[1];
        if (data_own == OWN_M0) rdy[0] = bus.HREADY;
        if (data_own == OWN_M1) rdy[1] = bus.HREADY;
        if (HRESET) rdy = 2'b11;
    end

    assign live    = in_act & rdy;
    assign req     = pend_v | live;
    assign any_req = |req;
    assign done    = any_req & bus.HREADY;

    always_comb begin
        grant = 1'b0;
        unique case (1'b1)
            lock_v:
                grant = lock_id;
            !lock_v && (req == 2'b11):
                grant = ROUND_ROBIN ? !last_win : 1'b0;
            !lock_v && (req != 2'b11):
                grant = req[1] & !req[0];
        endcase
    end

    always_comb begin
        src_addr  = pend_v[grant] ? pend_addr[grant]  : in_addr[grant];
        src_size  = pend_v[grant] ? pend_size[grant]  : in_size[grant];
        src_write = pend_v[grant] ? pend_write[grant] : in_write[grant];
    end

    assign bus.HTRANS = (any_req && !HRESET) ? HTRANS_NSEQ : HTRANS_IDLE;
    assign bus.HADDR  = any_req ? src_addr  : 32'd0;
    assign bus.HSIZE  = any_req ? src_size  : 3'd0;
    assign bus.HWRITE = any_req ? src_write : 1'b0;

    always_comb begin
        case (data_own)
            OWN_M0:  bus.HWDATA = m0.HWDATA;
            OWN_M1:  bus.HWDATA = m1.HWDATA;
            default: bus.HWDATA = 32'd0;
        endcase
    end

    assign m0.HREADY = rdy[0];
    assign m1.HREADY = rdy[1];
    assign m0.HRDATA = bus.HRDATA;
    assign m1.HRDATA = bus.HRDATA;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            pend_v     <= 2'b00;
            pend_write <= 2'b00;
            data_own   <= OWN_NONE;
            lock_v     <= 1'b0;
            lock_id    <= 1'b0;
            last_win   <= 1'b1;
            for (int x = 0; x < 2; x++) begin
                pend_addr[x] <= 32'd0;
                pend_size[x] <= 3'd0;
            end
        end else begin
            if (any_req) begin
                if (bus.HREADY) begin
                    data_own <= grant ? OWN_M1 : OWN_M0;
                    last_win <= grant;
                    lock_v   <= 1'b0;
                end else begin
                    lock_v  <= 1'b1;
                    lock_id <= grant;
                end
            end else if (bus.HREADY) begin
                data_own <= OWN_NONE;
            end
            // A live request that does not finish its address phase now is
            // parked so the bus is driven from stable registers afterwards.
            for (int x = 0; x < 2; x++) begin
                if (live[x] && !(done && grant == x[0])) begin
                    pend_v[x]     <= 1'b1;
                    pend_addr[x]  <= in_addr[x];
                    pend_size[x]  <= in_size[x];
                    pend_write[x] <= in_write[x];
                end else if (done && grant == x[0]) begin
                    pend_v[x] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahbl_master_arbiter.sv
// Bench for ahbl_master_arbiter: directed bring-up cases, then random traffic
// from two masters scored against an ordering/fairness model of the bus.
module tb_ahbl_master_arbiter;

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic        wr;
        logic [31:0] wdata;
    } xfer_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ahbl_master_arbiter_if m0 ();
    ahbl_master_arbiter_if m1 ();
    ahbl_master_arbiter_if bus ();
    ahbl_master_arbiter_if f0 ();
    ahbl_master_arbiter_if f1 ();
    ahbl_master_arbiter_if fbus ();

    ahbl_master_arbiter #(.ROUND_ROBIN(1'b1)) u_dut (
        .HCLK   (clk),
        .HRESET (rst),
        .m0     (m0),
        .m1     (m1),
        .bus    (bus)
    );

    ahbl_master_arbiter #(.ROUND_ROBIN(1'b0)) u_fix (
        .HCLK   (clk),
        .HRESET (rst),
        .m0     (f0),
        .m1     (f1),
        .bus    (fbus)
    );

    int total = 0;
    int bad   = 0;

    xfer_t       q0[$];
    xfer_t       q1[$];
    logic        mon_en = 1'b0;
    logic        last_m;
    logic        new_phase;
    logic [35:0] held;
    logic        dp_v;
    logic        dp_m;
    logic        dp_wr;
    logic [31:0] dp_wd;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_m(input int x, input logic act, input logic [31:0] a,
                         input logic [2:0] sz, input logic wr);
        if (x == 0) begin
            m0.HTRANS = act ? 2'b10 : 2'b00;
            m0.HADDR  = a;
            m0.HSIZE  = sz;
            m0.HWRITE = wr;
        end else begin
            m1.HTRANS = act ? 2'b10 : 2'b00;
            m1.HADDR  = a;
            m1.HSIZE  = sz;
            m1.HWRITE = wr;
        end
    endtask

    task automatic set_wd(input int x, input logic [31:0] wd);
        if (x == 0) m0.HWDATA = wd;
        else        m1.HWDATA = wd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_m(0, 1'b0, 32'd0, 3'd0, 1'b0);
        set_m(1, 1'b0, 32'd0, 3'd0, 1'b0);
        set_wd(0, 32'd0);
        set_wd(1, 32'd0);
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'd0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic xfer_t rand_xfer(input int x);
        xfer_t t;
        t.addr     = $urandom;
        t.addr[28] = x[0];
        t.size     = 3'($urandom_range(0, 2));
        t.wr       = 1'($urandom_range(0, 1));
        t.wdata    = $urandom;
        return t;
    endfunction

    // Model: every accepted transfer appears on the bus exactly once in issue
    // order; new address phases go to the sole requester, or under contention
    // to whichever master did not win the previous bus transfer.
    task automatic monitor_step();
        logic  r0, r1, ns, w, e;
        xfer_t t;
        r0 = (q0.size() != 0);
        r1 = (q1.size() != 0);
        ns = (bus.HTRANS == 2'b10);
        w  = bus.HADDR[28];
        chk("htrans", 64'(ns), 64'(r0 | r1));
        if (ns && new_phase) begin
            e = (r0 && r1) ? ~last_m : r1;
            chk("grant", 64'(w), 64'(e));
        end else if (ns) begin
            chk("hold", 64'({bus.HADDR, bus.HSIZE, bus.HWRITE}), 64'(held));
        end
        if (ns) held = {bus.HADDR, bus.HSIZE, bus.HWRITE};
        if (dp_v) begin
            chk("dready", 64'(dp_m ? m1.HREADY : m0.HREADY), 64'(bus.HREADY));
            if (dp_wr) chk("hwdata", 64'(bus.HWDATA), 64'(dp_wd));
            else chk("hrdata", 64'(dp_m ? m1.HRDATA : m0.HRDATA), 64'(bus.HRDATA));
        end
        if (bus.HREADY) dp_v = 1'b0;
        if (ns && bus.HREADY) begin
            if ((w ? q1.size() : q0.size()) == 0) begin
                total++;
                bad++;
                $display("FAIL pop: unexpected transfer %0h from master %0d",
                         bus.HADDR, w);
            end else begin
                t = w ? q1.pop_front() : q0.pop_front();
                chk("xfer", 64'({bus.HADDR, bus.HSIZE, bus.HWRITE}),
                    64'({t.addr, t.size, t.wr}));
                last_m = w;
                dp_v   = 1'b1;
                dp_m   = w;
                dp_wr  = t.wr;
                dp_wd  = t.wdata;
            end
        end
        new_phase = !(ns && !bus.HREADY);
    endtask

    always begin
        @(negedge clk);
        #1;
        if (mon_en) monitor_step();
    end

    initial begin
        xfer_t       cur [2];
        logic  [1:0] act;
        logic  [1:0] acc;
        logic [31:0] hw  [2];
        logic [31:0] a0;

        f0.HTRANS = 2'b10; f0.HSIZE = 3'd2; f0.HWRITE = 1'b0;
        f0.HADDR  = 32'h0000_0000; f0.HWDATA = 32'd0;
        f1.HTRANS = 2'b10; f1.HSIZE = 3'd2; f1.HWRITE = 1'b0;
        f1.HADDR  = 32'h1000_0000; f1.HWDATA = 32'd0;
        fbus.HREADY = 1'b1;
        fbus.HRDATA = 32'd0;

        // Reset with both masters requesting
        set_m(0, 1'b1, 32'h0000_0040, 3'd2, 1'b0);
        set_m(1, 1'b1, 32'h1000_0040, 3'd2, 1'b1);
        set_wd(0, 32'd0);
        set_wd(1, 32'd0);
        bus.HREADY = 1'b1;
        bus.HRDATA = 32'd0;
        #1;
        chk("rst_htrans", 64'(bus.HTRANS), 64'(2'b00));
        chk("rst_m0rdy", 64'(m0.HREADY), 64'd1);
        chk("rst_m1rdy", 64'(m1.HREADY), 64'd1);

        // Solo read on M0
        do_reset();
        set_m(0, 1'b1, 32'h2000_0010, 3'd2, 1'b0);
        @(negedge clk);
        chk("solo_haddr", 64'(bus.HADDR), 64'h2000_0010);
        chk("solo_m1rdy", 64'(m1.HREADY), 64'd1);
        step();
        set_m(0, 1'b0, 32'd0, 3'd0, 1'b0);
        bus.HRDATA = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("solo_hrdata", 64'(m0.HRDATA), 64'hDEAD_BEEF);
        chk("solo_m0rdy", 64'(m0.HREADY), 64'd1);
        chk("solo_m1rdy2", 64'(m1.HREADY), 64'd1);

        // Contention: M0 read vs M1 write
        do_reset();
        set_m(0, 1'b1, 32'h0000_0000, 3'd2, 1'b0);
        set_m(1, 1'b1, 32'h2000_0100, 3'd2, 1'b1);
        @(negedge clk);
        chk("cont_haddr0", 64'(bus.HADDR), 64'h0);
        chk("cont_m1rdy0", 64'(m1.HREADY), 64'd1);
        step();
        set_m(0, 1'b0, 32'd0, 3'd0, 1'b0);
        set_m(1, 1'b0, 32'd0, 3'd0, 1'b0);
        set_wd(1, 32'h0000_1234);
        @(negedge clk);
        chk("cont_haddr1", 64'({bus.HADDR, bus.HWRITE}), 64'({32'h2000_0100, 1'b1}));
        chk("cont_m1rdy1", 64'(m1.HREADY), 64'd0);
        step();
        @(negedge clk);
        chk("cont_hwdata", 64'(bus.HWDATA), 64'h1234);
        chk("cont_m1rdy2", 64'(m1.HREADY), 64'd1);
        set_wd(1, 32'd0);

        // Wait states during an M1 address phase
        do_reset();
        bus.HREADY = 1'b0;
        set_m(1, 1'b1, 32'h3000_0200, 3'd1, 1'b1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("ws_addr", 64'({bus.HADDR, bus.HTRANS, bus.HSIZE, bus.HWRITE}),
                64'({32'h3000_0200, 2'b10, 3'd1, 1'b1}));
            if (c == 2) chk("ws_m0rdy", 64'(m0.HREADY), 64'd0);
            step();
            set_m(1, 1'b0, 32'd0, 3'd0, 1'b0);
            set_m(0, c == 0, 32'h0000_0300, 3'd2, 1'b0);
        end
        bus.HREADY = 1'b1;
        @(negedge clk);
        chk("ws_done", 64'(bus.HADDR), 64'h3000_0200);
        step();
        @(negedge clk);
        chk("ws_m0next", 64'(bus.HADDR), 64'h0000_0300);
        step();

        // Reset while M1 is parked
        do_reset();
        set_m(0, 1'b1, 32'h0000_0400, 3'd2, 1'b0);
        set_m(1, 1'b1, 32'h1000_0400, 3'd2, 1'b0);
        step();
        set_m(0, 1'b0, 32'd0, 3'd0, 1'b0);
        set_m(1, 1'b0, 32'd0, 3'd0, 1'b0);
        @(negedge clk);
        chk("mr_m1rdy", 64'(m1.HREADY), 64'd0);
        #1;
        rst = 1'b1;
        #1;
        chk("mr_m1rdy_rst", 64'(m1.HREADY), 64'd1);
        chk("mr_htrans_rst", 64'(bus.HTRANS), 64'(2'b00));
        step();
        rst = 1'b0;
        set_m(0, 1'b1, 32'h0000_0500, 3'd2, 1'b0);
        @(negedge clk);
        chk("mr_m0_first", 64'({bus.HADDR, bus.HTRANS}), 64'({32'h0000_0500, 2'b10}));
        step();
        set_m(0, 1'b0, 32'd0, 3'd0, 1'b0);
        @(negedge clk);
        chk("mr_no_stale", 64'(bus.HTRANS), 64'(2'b00));
        step();

        // Fixed priority: M0 streaming always beats M1
        for (int c = 0; c < 8; c++) begin
            a0 = 32'h0000_1000 + 32'(c * 4);
            f0.HADDR = a0;
            @(negedge clk);
            chk("fixed_m0", 64'(fbus.HADDR), 64'(a0));
            step();
        end

        // Random two-master traffic
        do_reset();
        q0.delete();
        q1.delete();
        last_m    = 1'b1;
        new_phase = 1'b1;
        dp_v      = 1'b0;
        held      = '0;
        act       = 2'b00;
        acc       = 2'b00;
        hw[0]     = 32'd0;
        hw[1]     = 32'd0;
        cur[0]    = rand_xfer(0);
        cur[1]    = rand_xfer(1);
        mon_en    = 1'b1;
        repeat (2000) begin
            for (int x = 0; x < 2; x++) begin
                if (acc[x]) hw[x] = cur[x].wdata;
                if (!act[x] || acc[x]) begin
                    act[x] = ($urandom_range(0, 3) != 0);
                    cur[x] = rand_xfer(x);
                    set_m(x, act[x], cur[x].addr, cur[x].size, cur[x].wr);
                end
                set_wd(x, hw[x]);
            end
            bus.HREADY = ($urandom_range(0, 2) != 0);
            bus.HRDATA = $urandom;
            @(negedge clk);
            acc[0] = act[0] && m0.HREADY;
            acc[1] = act[1] && m1.HREADY;
            if (acc[0]) q0.push_back(cur[0]);
            if (acc[1]) q1.push_back(cur[1]);
            step();
        end
        mon_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
